// File: rtl/counter_up_nbit.sv
// Parameterised synchronous up counter with load, enable, programmable terminal value,
// and free-run/one-shot modes. It has a combinational carry for cascading instances.
module counter_up_nbit #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             enable_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic [WIDTH-1:0] mod_in,
    input  logic             mode_in,
    output logic [WIDTH-1:0] count_out,
    output logic             carry_out,
    output logic             done_out
);

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
            $error("counter_up_nbit: WIDTH must be in 2..16");
        end
    endgenerate

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_d;
    logic             done_d;
    logic             at_term;

    // Terminal compare is exact equality, so an out-of-range count climbs through the natural wrap.
    assign at_term = (count_out == mod_in);

    always_comb begin
        state_d = state_q;
        count_d = count_out;
        done_d  = done_out;
        if (load_in) begin
            count_d = d_in;
            done_d  = 1'b0;
            state_d = RUN;
        end else if (state_q == RUN && enable_in) begin
            if (at_term) begin
                if (mode_in) begin
                    state_d = HALT;
                    done_d  = 1'b1;
                end else begin
                    count_d = '0;
                end
            end else begin
                count_d = count_out + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q   <= RUN;
            count_out <= '0;
            done_out  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_out <= count_d;
            done_out  <= done_d;
        end
    end

    // Carry is suppressed whenever this edge will not actually take the terminal transition.
    assign carry_out = enable_in & (state_q == RUN) & at_term & ~load_in & ~reset_in;

endmodule

// File: tb/tb_counter_up_nbit.sv
// Scoreboard bench for counter_up_nbit: a reference model predicts each edge, and a
// two-instance cascade is checked across a full 0..63 sweep.
module tb_counter_up_nbit;

    logic       clk = 1'b0;
    logic       reset_in, enable_in, load_in, mode_in;
    logic [2:0] d_in, mod_in, count_out;
    logic       carry_out, done_out;

    logic       c_rst, c_en, c_lo_carry, c_hi_carry, c_lo_done, c_hi_done;
    logic [2:0] c_lo, c_hi;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [2:0] cnt;
        logic       done;
    } exp_t;

    exp_t sb_q[$];
    int   casc_q[$];

    logic [2:0] m_cnt  = 3'd0;
    logic       m_done = 1'b0;
    logic       m_halt = 1'b0;

    always #5 clk = ~clk;

    counter_up_nbit #(.WIDTH(3)) dut (
        .clk(clk), .reset_in(reset_in), .enable_in(enable_in), .load_in(load_in),
        .d_in(d_in), .mod_in(mod_in), .mode_in(mode_in),
        .count_out(count_out), .carry_out(carry_out), .done_out(done_out)
    );

    counter_up_nbit #(.WIDTH(3)) u_lo (
        .clk(clk), .reset_in(c_rst), .enable_in(c_en), .load_in(1'b0),
        .d_in(3'd0), .mod_in(3'd7), .mode_in(1'b0),
        .count_out(c_lo), .carry_out(c_lo_carry), .done_out(c_lo_done)
    );

    counter_up_nbit #(.WIDTH(3)) u_hi (
        .clk(clk), .reset_in(c_rst), .enable_in(c_lo_carry), .load_in(1'b0),
        .d_in(3'd0), .mod_in(3'd7), .mode_in(1'b0),
        .count_out(c_hi), .carry_out(c_hi_carry), .done_out(c_hi_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    // One clock of stimulus: check combinational carry, predict the edge, then compare after it.
    task automatic step(input logic rst, input logic en, input logic ld,
                        input logic [2:0] d, input logic [2:0] mod, input logic mode);
        exp_t e;
        logic exp_carry;
        @(negedge clk);
        reset_in  = rst;
        enable_in = en;
        load_in   = ld;
        d_in      = d;
        mod_in    = mod;
        mode_in   = mode;
        #1;
        exp_carry = en & ~m_halt & (m_cnt == mod) & ~ld & ~rst;
        check_eq("carry", 32'(carry_out), 32'(exp_carry));
        if (rst) begin
            m_cnt = 3'd0; m_done = 1'b0; m_halt = 1'b0;
        end else if (ld) begin
            m_cnt = d; m_done = 1'b0; m_halt = 1'b0;
        end else if (!m_halt && en) begin
            if (m_cnt == mod) begin
                if (mode) begin
                    m_halt = 1'b1; m_done = 1'b1;
                end else begin
                    m_cnt = 3'd0;
                end
            end else begin
                m_cnt = m_cnt + 3'd1;
            end
        end
        sb_q.push_back('{cnt: m_cnt, done: m_done});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("count", 32'(count_out), 32'(e.cnt));
        check_eq("done", 32'(done_out), 32'(e.done));
    endtask

    task automatic run(input int n, input logic [2:0] mod, input logic mode);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 3'd0, mod, mode);
    endtask

    initial begin
        int cur;
        reset_in = 1'b1; enable_in = 1'b0; load_in = 1'b0;
        d_in = 3'd0; mod_in = 3'd7; mode_in = 1'b0;
        c_rst = 1'b1; c_en = 1'b0;

        // Reset state, with enable asserted to show it is ignored.
        step(1'b1, 1'b1, 1'b0, 3'd0, 3'd7, 1'b0);
        step(1'b1, 1'b1, 1'b0, 3'd0, 3'd7, 1'b0);
        check_eq("reset_count", 32'(count_out), 32'd0);

        // Free-run, full range.
        run(10, 3'd7, 1'b0);

        // Modulus 4 with an enable gap at count 2.
        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0);
        run(2, 3'd4, 1'b0);
        step(1'b0, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0);
        step(1'b0, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0);
        check_eq("hold_at_2", 32'(count_out), 32'd2);
        run(6, 3'd4, 1'b0);

        // One-shot to 5, ten ignored enables, then reload and resume.
        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 1'b1);
        run(16, 3'd5, 1'b1);
        check_eq("oneshot_hold", 32'(count_out), 32'd5);
        check_eq("oneshot_done", 32'(done_out), 32'd1);
        step(1'b0, 1'b1, 1'b1, 3'd1, 3'd5, 1'b1);
        run(3, 3'd5, 1'b1);

        // Load beats terminal count.
        step(1'b0, 1'b0, 1'b1, 3'd7, 3'd7, 1'b0);
        step(1'b0, 1'b1, 1'b1, 3'd3, 3'd7, 1'b0);
        check_eq("load_prio", 32'(count_out), 32'd3);
        run(3, 3'd7, 1'b0);

        // Out-of-range start climbs through the natural wrap.
        step(1'b0, 1'b0, 1'b1, 3'd5, 3'd2, 1'b0);
        run(8, 3'd2, 1'b0);

        // Reset while halted.
        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 1'b1);
        run(7, 3'd5, 1'b1);
        step(1'b1, 1'b1, 1'b0, 3'd0, 3'd5, 1'b1);
        check_eq("halt_reset_done", 32'(done_out), 32'd0);
        run(3, 3'd5, 1'b1);

        // Zero terminal value in both modes.
        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
        run(4, 3'd0, 1'b0);
        run(3, 3'd0, 1'b1);

        // Random mix, mode/mod changing every cycle.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 31) == 0), 1'($urandom), ($urandom_range(0, 7) == 0),
                 3'($urandom), 3'($urandom), 1'($urandom));
        end

        // Cascade: 0..63 then wrap.
        @(negedge clk);
        #1;
        check_eq("casc_reset", 32'({c_hi, c_lo}), 32'd0);
        cur = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            c_rst = 1'b0;
            c_en  = 1'b1;
            #1;
            check_eq("casc_carry", 32'(c_hi_carry), 32'(cur == 63));
            cur = (cur + 1) % 64;
            casc_q.push_back(cur);
            @(posedge clk);
            #1;
            check_eq("casc_count", 32'({c_hi, c_lo}), 32'(casc_q.pop_front()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
